single_cycle_mips: RTL and testbench

- 16-bit-data, single-cycle MIPS-style processor: fetch, decode, execute, memory and writeback complete in one clock cycle.
- 32-bit instruction words, 10-bit word-addressed PC, 16 x 16-bit register file, separate instruction and data memories.
- Top-level CPU used by program-level benches. Those benches preload instruction memory and dump registers and memories hierarchically.

---
 rtl/single_cycle_mips_pkg.sv | 57 +++++
 rtl/single_cycle_mips_alu.sv | 29 ++
 rtl/single_cycle_mips_control.sv | 58 +++++
 rtl/single_cycle_mips_dmem.sv | 20 ++
 rtl/single_cycle_mips_imem.sv | 13 +
 rtl/single_cycle_mips_regfile.sv | 29 ++
 rtl/single_cycle_mips.sv | 91 +++++++++
 tb/tb_single_cycle_mips.sv | 244 ++++++++++++++++++++++++
 8 files changed

// File: rtl/single_cycle_mips_pkg.sv
// Shared constants and types for the single-cycle MIPS-style CPU:
// widths, opcode/funct encodings, ALU operation codes and the control bundle.
package single_cycle_mips_pkg;

  localparam int DATA_W = 16;
  localparam int PC_W   = 10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LI    = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_NOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic    reg_dst;
    logic    reg_write;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
    logic    branch_not;
    logic    jump_and_link;
    logic    jump_reg;
    logic    jump;
    logic    alu_src;
    logic    load_imm;
    alu_op_e alu_op;
  } ctrl_t;

endpackage

// File: rtl/single_cycle_mips_alu.sv
// 16-bit ALU: logic ops, add/sub, shift-left and signed set-less-than.
module single_cycle_mips_alu
  import single_cycle_mips_pkg::*;
(
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res,
  output logic              zero
);

  always_comb begin
    res = {DATA_W{1'b0}};
    case (op)
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_ADD: res = a + b;
      ALU_XOR: res = a ^ b;
      ALU_NOR: res = ~(a | b);
      ALU_SLL: res = a << b[3:0];
      ALU_SUB: res = a - b;
      ALU_SLT: res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: res = {DATA_W{1'b0}};
    endcase
  end

  assign zero = (res == {DATA_W{1'b0}});

endmodule

// File: rtl/single_cycle_mips_control.sv
// Main decoder: maps opcode/funct to the datapath control bundle.
module single_cycle_mips_control
  import single_cycle_mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  logic    r_valid_s;
  alu_op_e r_op_s;

  always_comb begin
    r_valid_s = 1'b1;
    r_op_s    = ALU_ADD;
    case (funct)
      FN_ADD:  r_op_s = ALU_ADD;
      FN_SUB:  r_op_s = ALU_SUB;
      FN_AND:  r_op_s = ALU_AND;
      FN_OR:   r_op_s = ALU_OR;
      FN_XOR:  r_op_s = ALU_XOR;
      FN_NOR:  r_op_s = ALU_NOR;
      FN_SLT:  r_op_s = ALU_SLT;
      FN_SLL:  r_op_s = ALU_SLL;
      default: r_valid_s = 1'b0;   // jr and unknown funct write no register
    endcase
  end

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst   = r_valid_s;
        ctrl.reg_write = r_valid_s;
        ctrl.alu_op    = r_op_s;
        ctrl.jump_reg  = (funct == FN_JR);
      end
      OP_ADDI: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_ADD; end
      OP_SLTI: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SLT; end
      OP_ANDI: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_AND; end
      OP_ORI:  begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_OR;  end
      OP_LI:   begin ctrl.load_imm = 1'b1; ctrl.reg_write = 1'b1; end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      OP_SW:  begin ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; end
      OP_BEQ: begin ctrl.branch = 1'b1; ctrl.alu_op = ALU_SUB; end
      OP_BNE: begin ctrl.branch_not = 1'b1; ctrl.alu_op = ALU_SUB; end
      OP_J:   ctrl.jump = 1'b1;
      OP_JAL: begin ctrl.jump_and_link = 1'b1; ctrl.reg_write = 1'b1; end
      default: ctrl.alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/single_cycle_mips_dmem.sv
// Data RAM, 1024 x 16, combinational read and write on the rising edge; never cleared by reset.
module single_cycle_mips_dmem
  import single_cycle_mips_pkg::*;
(
  input  logic              clock,
  input  logic              write_en,
  input  logic [PC_W-1:0]   addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data
);

  logic [DATA_W-1:0] memory [0:(1<<PC_W)-1];

  assign read_data = memory[addr];

  always_ff @(posedge clock) begin
    if (write_en) memory[addr] <= write_data;
  end

endmodule

// File: rtl/single_cycle_mips_imem.sv
// Instruction ROM, 1024 x 32, read combinationally; contents are preloaded externally.
module single_cycle_mips_imem
  import single_cycle_mips_pkg::*;
(
  input  logic [PC_W-1:0] addr,
  output logic [31:0]     data
);

  logic [31:0] memory [0:(1<<PC_W)-1];

  assign data = memory[addr];

endmodule

// File: rtl/single_cycle_mips_regfile.sv
// 16 x 16 register file: two combinational read ports, one write port, r0 hard-wired to zero.
module single_cycle_mips_regfile
  import single_cycle_mips_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        read_reg1,
  input  logic [3:0]        read_reg2,
  input  logic [3:0]        write_reg,
  input  logic              write_en,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  logic [DATA_W-1:0] registers [0:15];

  assign read_data1 = (read_reg1 == 4'd0) ? {DATA_W{1'b0}} : registers[read_reg1];
  assign read_data2 = (read_reg2 == 4'd0) ? {DATA_W{1'b0}} : registers[read_reg2];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) registers[i] <= {DATA_W{1'b0}};
    end else if (write_en && (write_reg != 4'd0)) begin
      registers[write_reg] <= write_data;
    end
  end

endmodule

// File: rtl/single_cycle_mips.sv
// Single-cycle 16-bit MIPS-style CPU top: PC, decode, ALU, memories and writeback.
module single_cycle_mips
  import single_cycle_mips_pkg::*;
(
  input logic clock,
  input logic reset
);

  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_plus1_s, branch_target_s, next_pc_s;
  logic [31:0]       instruction;
  logic [5:0]        opcode, funct_s;
  logic [DATA_W-1:0] imm_s;
  ctrl_t             ctrl_s;
  logic              regDst, regWrite, memWrite, memToReg, branch, branchNot;
  logic              jumpAndLink, jumpReg, jump, aluSrc, loadImm;
  alu_op_e           aluOp;
  logic [3:0]        read_reg1, read_reg2, write_reg;
  logic [DATA_W-1:0] read_data1, read_data2, write_back, mem_data_s;
  logic [DATA_W-1:0] alu_a, alu_b, alu_res;
  logic              alu_zero, branch_taken_s;
  logic              unused_fields_s;

  assign opcode    = instruction[31:26];
  assign read_reg1 = instruction[24:21];
  assign read_reg2 = instruction[19:16];
  assign funct_s   = instruction[5:0];
  assign imm_s     = instruction[15:0];
  assign unused_fields_s = instruction[25] ^ instruction[20];

  single_cycle_mips_imem inst_mem (.addr(pc), .data(instruction));

  single_cycle_mips_control ctrl_unit (.opcode(opcode), .funct(funct_s), .ctrl(ctrl_s));

  assign regDst      = ctrl_s.reg_dst;
  assign regWrite    = ctrl_s.reg_write;
  assign memWrite    = ctrl_s.mem_write;
  assign memToReg    = ctrl_s.mem_to_reg;
  assign branch      = ctrl_s.branch;
  assign branchNot   = ctrl_s.branch_not;
  assign jumpAndLink = ctrl_s.jump_and_link;
  assign jumpReg     = ctrl_s.jump_reg;
  assign jump        = ctrl_s.jump;
  assign aluSrc      = ctrl_s.alu_src;
  assign loadImm     = ctrl_s.load_imm;
  assign aluOp       = ctrl_s.alu_op;

  assign write_reg = regDst ? instruction[14:11] : (jumpAndLink ? 4'd15 : read_reg2);

  single_cycle_mips_regfile regs (
    .clock(clock), .reset(reset),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .write_reg(write_reg),
    .write_en(regWrite), .write_data(write_back),
    .read_data1(read_data1), .read_data2(read_data2)
  );

  assign alu_a = read_data1;
  assign alu_b = aluSrc ? imm_s : read_data2;

  single_cycle_mips_alu alu (.op(aluOp), .a(alu_a), .b(alu_b), .res(alu_res), .zero(alu_zero));

  // Stores are suppressed while reset is held so memory survives a reset.
  single_cycle_mips_dmem data_mem (
    .clock(clock), .write_en(memWrite & ~reset), .addr(alu_res[PC_W-1:0]),
    .write_data(read_data2), .read_data(mem_data_s)
  );

  always_comb begin
    if (jumpAndLink)   write_back = {{(DATA_W-PC_W){1'b0}}, pc_plus1_s};
    else if (loadImm)  write_back = imm_s;
    else if (memToReg) write_back = mem_data_s;
    else               write_back = alu_res;
  end

  assign pc_plus1_s      = pc + 10'd1;
  assign branch_target_s = pc_plus1_s + imm_s[PC_W-1:0];
  assign branch_taken_s  = (branch & alu_zero) | (branchNot & ~alu_zero);

  always_comb begin
    if (jumpReg)                  next_pc_s = read_data1[PC_W-1:0];
    else if (jump || jumpAndLink) next_pc_s = instruction[PC_W-1:0];
    else if (branch_taken_s)      next_pc_s = branch_target_s;
    else                          next_pc_s = pc_plus1_s;
  end

  always_ff @(posedge clock) begin
    if (reset) pc <= {PC_W{1'b0}};
    else       pc <= next_pc_s;
  end

endmodule

// File: tb/tb_single_cycle_mips.sv
// Program-level bench: loads small programs, queues expected architectural state, compares after running.
module tb_single_cycle_mips;

  logic clock;
  logic reset;

  single_cycle_mips dut (.clock(clock), .reset(reset));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    int          kind;   // 0 register, 1 pc, 2 data memory
    int          idx;
    logic [15:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run;
  int   tests_failed;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010, OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LI = 6'b001111, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_XOR = 6'b100110, F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010, F_SLL = 6'b000000, F_JR = 6'b001000;

  function automatic logic [31:0] rtype(input logic [3:0] rs, input logic [3:0] rt,
                                        input logic [3:0] rd, input logic [5:0] fn);
    return {OP_R, 1'b0, rs, 1'b0, rt, 1'b0, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [3:0] rs,
                                        input logic [3:0] rt, input logic [15:0] imm);
    return {op, 1'b0, rs, 1'b0, rt, imm};
  endfunction

  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [9:0] target);
    return {op, 16'h0000, target};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) dut.inst_mem.memory[i] = 32'h0000_0000;
  endtask

  task automatic put(input int addr, input logic [31:0] word);
    dut.inst_mem.memory[addr] = word;
  endtask

  task automatic exp_reg(input string tag, input int idx, input logic [15:0] v);
    sb_q.push_back('{tag, 0, idx, v});
  endtask

  task automatic exp_pc(input string tag, input logic [15:0] v);
    sb_q.push_back('{tag, 1, 0, v});
  endtask

  task automatic exp_mem(input string tag, input int idx, input logic [15:0] v);
    sb_q.push_back('{tag, 2, idx, v});
  endtask

  task automatic drain();
    exp_t        e;
    logic [15:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        0:       obs = dut.regs.registers[e.idx];
        1:       obs = {6'b000000, dut.pc};
        2:       obs = dut.data_mem.memory[e.idx];
        default: obs = 16'hxxxx;
      endcase
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    clear_prog();

    // reset state
    do_reset();
    exp_pc("rst_pc", 16'd0);
    exp_reg("rst_r1", 1, 16'h0000);
    exp_reg("rst_r15", 15, 16'h0000);
    drain();

    // subtraction program
    clear_prog();
    put(0, itype(OP_LI, 4'd0, 4'd1, 16'd9));
    put(1, itype(OP_LI, 4'd0, 4'd2, 16'd4));
    put(2, rtype(4'd1, 4'd2, 4'd3, F_SUB));
    do_reset();
    exp_reg("sub_r1", 1, 16'd9);
    exp_reg("sub_r2", 2, 16'd4);
    exp_reg("sub_r3", 3, 16'h0005);
    exp_pc("sub_pc", 16'd3);
    run(3);
    drain();

    // memory round trip
    clear_prog();
    put(0, itype(OP_LI, 4'd0, 4'd1, 16'h1234));
    put(1, itype(OP_LI, 4'd0, 4'd2, 16'd5));
    put(2, itype(OP_SW, 4'd2, 4'd1, 16'd3));
    put(3, itype(OP_LW, 4'd2, 4'd4, 16'd3));
    do_reset();
    exp_mem("sw_mem8", 8, 16'h1234);
    exp_reg("lw_r4", 4, 16'h1234);
    exp_pc("mem_pc", 16'd4);
    run(4);
    drain();

    // reset mid-program: state cleared, data memory kept
    reset = 1'b1;
    @(posedge clock); #1;
    exp_pc("midrst_pc", 16'd0);
    exp_reg("midrst_r1", 1, 16'h0000);
    exp_reg("midrst_r2", 2, 16'h0000);
    exp_reg("midrst_r4", 4, 16'h0000);
    exp_mem("midrst_mem8", 8, 16'h1234);
    drain();
    reset = 1'b0;

    // beq taken
    clear_prog();
    put(0, itype(OP_LI, 4'd0, 4'd1, 16'd7));
    put(1, itype(OP_LI, 4'd0, 4'd2, 16'd7));
    put(4, itype(OP_BEQ, 4'd1, 4'd2, 16'd2));
    do_reset();
    exp_pc("beq_pc", 16'd7);
    run(5);
    drain();

    // bne not taken, then bne taken against r0
    put(4, itype(OP_BNE, 4'd1, 4'd2, 16'd2));
    put(5, itype(OP_BNE, 4'd1, 4'd0, 16'd3));
    do_reset();
    exp_pc("bne_nt_pc", 16'd5);
    run(5);
    drain();
    exp_pc("bne_t_pc", 16'd9);
    run(1);
    drain();

    // jal / jr / j
    clear_prog();
    put(6, jtype(OP_JAL, 10'd20));
    put(20, rtype(4'd15, 4'd0, 4'd0, F_JR));
    put(7, jtype(OP_J, 10'd30));
    do_reset();
    exp_pc("jal_pc", 16'd20);
    exp_reg("jal_r15", 15, 16'd7);
    run(7);
    drain();
    exp_pc("jr_pc", 16'd7);
    exp_reg("jr_r0", 0, 16'h0000);
    run(1);
    drain();
    exp_pc("j_pc", 16'd30);
    exp_reg("j_r15", 15, 16'd7);
    run(1);
    drain();

    // r0 write ignored, signed slt, wrap, unknown opcode/funct
    clear_prog();
    put(0, itype(OP_LI, 4'd0, 4'd0, 16'hFFFF));
    put(1, itype(OP_LI, 4'd0, 4'd1, 16'hFFFF));
    put(2, itype(OP_LI, 4'd0, 4'd2, 16'd1));
    put(3, rtype(4'd1, 4'd2, 4'd3, F_SLT));
    put(4, itype(OP_ADDI, 4'd1, 4'd4, 16'd1));
    put(5, itype(6'b111111, 4'd1, 4'd13, 16'h5555));
    put(6, rtype(4'd1, 4'd2, 4'd14, 6'b111111));
    put(7, rtype(4'd2, 4'd1, 4'd5, F_SLT));
    do_reset();
    exp_reg("r0_zero", 0, 16'h0000);
    exp_reg("slt_neg", 3, 16'd1);
    exp_reg("addi_wrap", 4, 16'h0000);
    exp_reg("badop_r13", 13, 16'h0000);
    exp_reg("badfn_r14", 14, 16'h0000);
    exp_reg("slt_pos", 5, 16'd0);
    exp_pc("misc_pc", 16'd8);
    run(8);
    drain();

    // ALU mix
    clear_prog();
    put(0, itype(OP_LI, 4'd0, 4'd1, 16'h00F0));
    put(1, itype(OP_LI, 4'd0, 4'd2, 16'h0F0F));
    put(2, rtype(4'd1, 4'd2, 4'd3, F_AND));
    put(3, rtype(4'd1, 4'd2, 4'd4, F_OR));
    put(4, rtype(4'd1, 4'd2, 4'd5, F_XOR));
    put(5, rtype(4'd1, 4'd2, 4'd6, F_NOR));
    put(6, rtype(4'd1, 4'd2, 4'd7, F_ADD));
    put(7, itype(OP_LI, 4'd0, 4'd8, 16'd4));
    put(8, rtype(4'd1, 4'd8, 4'd9, F_SLL));
    put(9, itype(OP_ANDI, 4'd2, 4'd10, 16'h00FF));
    put(10, itype(OP_ORI, 4'd1, 4'd11, 16'h000F));
    put(11, itype(OP_SLTI, 4'd1, 4'd12, 16'h0100));
    put(12, rtype(4'd1, 4'd2, 4'd13, F_SUB));
    do_reset();
    exp_reg("and", 3, 16'h0000);
    exp_reg("or", 4, 16'h0FFF);
    exp_reg("xor", 5, 16'h0FFF);
    exp_reg("nor", 6, 16'hF000);
    exp_reg("add", 7, 16'h0FFF);
    exp_reg("sll", 9, 16'h0F00);
    exp_reg("andi", 10, 16'h000F);
    exp_reg("ori", 11, 16'h00FF);
    exp_reg("slti", 12, 16'd1);
    exp_reg("sub_wrap", 13, 16'hF1E1);
    exp_pc("alu_pc", 16'd13);
    run(13);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
